alu_issue_stage: RTL and testbench

ID/EX pipeline stage that drives the ALU interface: it produces input1, input2 and ALUCtrl each cycle from a decoded instruction.
- Registers the decoded operands and control, resolves EX/MEM and MEM/WB forwarding, and selects the immediate.
- Detects load-use hazards and inserts bubbles; honours external stall and flush.
- Sits between the decode stage and the ALU in the pipelined MIPS core.

---
 rtl/alu_issue_stage_pkg.sv | 28 ++
 rtl/alu_issue_stage_if.sv | 44 ++++
 rtl/alu_issue_stage_fwd_mux.sv | 64 ++++++
 rtl/alu_issue_stage.sv | 196 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ID/EX issue stage of the pipelined MIPS core:
//   - ALUCtrl operation codes driven towards the ALU
//   - default widths for operands, register indices and ALUCtrl
//   - operand forward-source selection encoding
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CTRL_W_DEF = 4;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Where an EX operand is taken from
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_if
// Decode-to-issue bus. The decode stage (master) presents one decoded
// instruction per cycle; the issue stage (slave) answers with id_ready.
//   id_valid / id_ready           : transfer handshake
//   id_rs_data / id_rt_data       : register-file operand reads
//   id_imm                        : sign-extended immediate
//   id_rs / id_rt / id_rd         : source and destination indices
//   id_alu_src                    : 1 = second operand is the immediate
//   id_ALUCtrl                    : ALU operation
//   id_reg_write / id_mem_read    : writes rd / is a load
// ---------------------------------------------------------------------------
interface alu_issue_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
);

  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_alu_src;
  logic [CTRL_W-1:0] id_ALUCtrl;
  logic              id_reg_write;
  logic              id_mem_read;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_src, id_ALUCtrl, id_reg_write, id_mem_read,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_src, id_ALUCtrl, id_reg_write, id_mem_read,
    output id_ready
  );

endinterface

// File: rtl/alu_issue_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// alu_fwd_mux
// Resolves one EX operand against the two bypass sources.
//   idx_i        : register index the operand was read from
//   reg_val_i    : value read from the register file at decode
//   exmem_*_i    : EX/MEM bypass (write enable, destination, result)
//   memwb_*_i    : MEM/WB bypass (write enable, destination, result)
//   val_o        : operand value to present to the ALU
// EX/MEM is younger than MEM/WB, so it wins when both match. Register 0 is
// hard-wired to zero and must never pick up a bypassed value.
// ---------------------------------------------------------------------------
module alu_fwd_mux
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] idx_i,
  input  logic [DATA_W-1:0] reg_val_i,
  input  logic              exmem_we_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_val_i,
  input  logic              memwb_we_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_val_i,
  output logic [DATA_W-1:0] val_o
);

  logic     idx_nonzero_s;
  logic     exmem_hit_s;
  logic     memwb_hit_s;
  fwd_sel_e sel_s;

  // Match each bypass source against the operand index
  always_comb begin
    idx_nonzero_s = (idx_i != {REG_AW{1'b0}});
    exmem_hit_s   = exmem_we_i & idx_nonzero_s & (exmem_rd_i == idx_i);
    memwb_hit_s   = memwb_we_i & idx_nonzero_s & (memwb_rd_i == idx_i);
  end

  // Pick the youngest matching source
  always_comb begin
    sel_s = FWD_REG;
    if (exmem_hit_s) begin
      sel_s = FWD_EXMEM;
    end else if (memwb_hit_s) begin
      sel_s = FWD_MEMWB;
    end else begin
      sel_s = FWD_REG;
    end
  end

  // Operand value for the selected source
  always_comb begin
    val_o = reg_val_i;
    case (sel_s)
      FWD_EXMEM: val_o = exmem_val_i;
      FWD_MEMWB: val_o = memwb_val_i;
      FWD_REG:   val_o = reg_val_i;
      default:   val_o = reg_val_i;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// ID/EX pipeline register feeding the ALU.
//   clk, rst          : clock, synchronous active-high reset
//   id_bus (slave)    : decoded instruction from the decode stage + id_ready
//   stall             : freeze the EX registers
//   flush             : kill the instruction entering EX
//   exmem_* / memwb_* : bypass sources for operand forwarding
//   input1, input2    : ALU operands (forwarded / immediate-selected)
//   ALUCtrl           : ALU operation
//   ex_valid, ex_rd, ex_reg_write, ex_mem_read : EX-stage sideband
// Edge priority: rst > flush > stall > load-use bubble > normal capture.
// A load in EX whose destination is read by the ID instruction cannot be
// bypassed in time, so the ID instruction is held (id_ready low) for one
// cycle and a bubble enters EX instead.
// ---------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_issue_stage_if.slave     id_bus,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 exmem_reg_write,
  input  logic [REG_AW-1:0]    exmem_rd,
  input  logic [DATA_W-1:0]    exmem_result,
  input  logic                 memwb_reg_write,
  input  logic [REG_AW-1:0]    memwb_rd,
  input  logic [DATA_W-1:0]    memwb_result,
  output logic [DATA_W-1:0]    input1,
  output logic [DATA_W-1:0]    input2,
  output logic [CTRL_W-1:0]    ALUCtrl,
  output logic                 ex_valid,
  output logic [REG_AW-1:0]    ex_rd,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read
);

  // EX pipeline registers
  logic              ex_valid_q,     ex_valid_d;
  logic [DATA_W-1:0] rs_data_q,      rs_data_d;
  logic [DATA_W-1:0] rt_data_q,      rt_data_d;
  logic [DATA_W-1:0] imm_q,          imm_d;
  logic [REG_AW-1:0] rs_q,           rs_d;
  logic [REG_AW-1:0] rt_q,           rt_d;
  logic [REG_AW-1:0] rd_q,           rd_d;
  logic              alu_src_q,      alu_src_d;
  logic [CTRL_W-1:0] ctrl_q,         ctrl_d;
  logic              reg_write_q,    reg_write_d;
  logic              mem_read_q,     mem_read_d;

  logic              load_use_s;
  logic [DATA_W-1:0] rs_fwd_s;
  logic [DATA_W-1:0] rt_fwd_s;

  // Load-use hazard: the EX load's result is not yet available for bypass
  always_comb begin
    load_use_s = id_bus.id_valid & ex_valid_q & mem_read_q &
                 (rd_q != {REG_AW{1'b0}}) &
                 ((id_bus.id_rs == rd_q) | (id_bus.id_rt == rd_q));
  end

  // Accept from decode unless frozen or holding back for a load-use bubble
  assign id_bus.id_ready = ~stall & ~load_use_s;

  // Next-state selection for the EX registers in priority order
  always_comb begin
    ex_valid_d  = ex_valid_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    alu_src_d   = alu_src_q;
    ctrl_d      = ctrl_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (stall) begin
      ex_valid_d = ex_valid_q;
    end else if (load_use_s) begin
      ex_valid_d = 1'b0;
    end else if (id_bus.id_valid) begin
      ex_valid_d  = 1'b1;
      rs_data_d   = id_bus.id_rs_data;
      rt_data_d   = id_bus.id_rt_data;
      imm_d       = id_bus.id_imm;
      rs_d        = id_bus.id_rs;
      rt_d        = id_bus.id_rt;
      rd_d        = id_bus.id_rd;
      alu_src_d   = id_bus.id_alu_src;
      ctrl_d      = id_bus.id_ALUCtrl;
      reg_write_d = id_bus.id_reg_write;
      mem_read_d  = id_bus.id_mem_read;
    end else begin
      ex_valid_d = 1'b0;
    end
  end

  // EX register bank with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      rs_data_q   <= {DATA_W{1'b0}};
      rt_data_q   <= {DATA_W{1'b0}};
      imm_q       <= {DATA_W{1'b0}};
      rs_q        <= {REG_AW{1'b0}};
      rt_q        <= {REG_AW{1'b0}};
      rd_q        <= {REG_AW{1'b0}};
      alu_src_q   <= 1'b0;
      ctrl_q      <= {CTRL_W{1'b0}};
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      alu_src_q   <= alu_src_d;
      ctrl_q      <= ctrl_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  alu_fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs (
    .idx_i       (rs_q),
    .reg_val_i   (rs_data_q),
    .exmem_we_i  (exmem_reg_write),
    .exmem_rd_i  (exmem_rd),
    .exmem_val_i (exmem_result),
    .memwb_we_i  (memwb_reg_write),
    .memwb_rd_i  (memwb_rd),
    .memwb_val_i (memwb_result),
    .val_o       (rs_fwd_s)
  );

  alu_fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rt (
    .idx_i       (rt_q),
    .reg_val_i   (rt_data_q),
    .exmem_we_i  (exmem_reg_write),
    .exmem_rd_i  (exmem_rd),
    .exmem_val_i (exmem_result),
    .memwb_we_i  (memwb_reg_write),
    .memwb_rd_i  (memwb_rd),
    .memwb_val_i (memwb_result),
    .val_o       (rt_fwd_s)
  );

  // ALU-facing outputs; a bubble presents an inert AND of zeros
  always_comb begin
    input1       = {DATA_W{1'b0}};
    input2       = {DATA_W{1'b0}};
    ALUCtrl      = {CTRL_W{1'b0}};
    ex_valid     = ex_valid_q;
    ex_rd        = {REG_AW{1'b0}};
    ex_reg_write = 1'b0;
    ex_mem_read  = 1'b0;
    if (ex_valid_q) begin
      input1 = rs_fwd_s;
      if (alu_src_q) begin
        input2 = imm_q;
      end else begin
        input2 = rt_fwd_s;
      end
      ALUCtrl      = ctrl_q;
      ex_rd        = rd_q;
      ex_reg_write = reg_write_q;
      ex_mem_read  = mem_read_q;
    end else begin
      input1       = {DATA_W{1'b0}};
      input2       = {DATA_W{1'b0}};
      ALUCtrl      = {CTRL_W{1'b0}};
      ex_rd        = {REG_AW{1'b0}};
      ex_reg_write = 1'b0;
      ex_mem_read  = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Self-checking bench for alu_issue_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the EX
// slot kept in this file.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) id_bus ();

  logic          stall, flush;
  logic          exmem_reg_write, memwb_reg_write;
  logic [AW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;
  logic [DW-1:0] input1, input2;
  logic [CW-1:0] ALUCtrl;
  logic          ex_valid, ex_reg_write, ex_mem_read;
  logic [AW-1:0] ex_rd;

  alu_issue_stage #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_bus          (id_bus),
    .stall           (stall),
    .flush           (flush),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .input1          (input1),
    .input2          (input2),
    .ALUCtrl         (ALUCtrl),
    .ex_valid        (ex_valid),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic last_acc;

  // Model of the instruction sitting in EX
  logic          m_valid, m_alu_src, m_rw, m_mr;
  logic [DW-1:0] m_rs_data, m_rt_data, m_imm;
  logic [AW-1:0] m_rs, m_rt, m_rd;
  logic [CW-1:0] m_ctrl;

  // Single comparison point for the whole bench
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Youngest in-flight producer of a register wins; register 0 is always zero-sourced
  function automatic logic [DW-1:0] fwd_val(input logic [AW-1:0] idx, input logic [DW-1:0] v);
    if (idx != 0 && exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (idx != 0 && memwb_reg_write && memwb_rd == idx) return memwb_result;
    return v;
  endfunction

  function automatic logic hazard();
    return id_bus.id_valid && m_valid && m_mr && (m_rd != 0) &&
           (id_bus.id_rs == m_rd || id_bus.id_rt == m_rd);
  endfunction

  task automatic model_clear();
    m_valid = 0; m_alu_src = 0; m_rw = 0; m_mr = 0;
    m_rs_data = 0; m_rt_data = 0; m_imm = 0;
    m_rs = 0; m_rt = 0; m_rd = 0; m_ctrl = 0;
  endtask

  task automatic check_outputs(input logic hz);
    check_eq("id_ready", id_bus.id_ready, !stall && !hz);
    check_eq("ex_valid", ex_valid, m_valid);
    if (m_valid) begin
      check_eq("input1", input1, fwd_val(m_rs, m_rs_data));
      check_eq("input2", input2, m_alu_src ? m_imm : fwd_val(m_rt, m_rt_data));
      check_eq("ALUCtrl", ALUCtrl, m_ctrl);
      check_eq("ex_rd", ex_rd, m_rd);
      check_eq("ex_reg_write", ex_reg_write, m_rw);
      check_eq("ex_mem_read", ex_mem_read, m_mr);
    end else begin
      check_eq("bubble_in1", input1, 0);
      check_eq("bubble_in2", input2, 0);
      check_eq("bubble_ctrl", ALUCtrl, 0);
      check_eq("bubble_rw", ex_reg_write, 0);
      check_eq("bubble_mr", ex_mem_read, 0);
    end
  endtask

  task automatic model_edge(input logic hz);
    if (rst) model_clear();
    else if (flush) m_valid = 0;
    else if (stall) m_valid = m_valid;
    else if (hz) m_valid = 0;
    else if (id_bus.id_valid) begin
      m_valid = 1;
      m_rs_data = id_bus.id_rs_data; m_rt_data = id_bus.id_rt_data; m_imm = id_bus.id_imm;
      m_rs = id_bus.id_rs; m_rt = id_bus.id_rt; m_rd = id_bus.id_rd;
      m_alu_src = id_bus.id_alu_src; m_ctrl = id_bus.id_ALUCtrl;
      m_rw = id_bus.id_reg_write; m_mr = id_bus.id_mem_read;
    end else m_valid = 0;
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge, return at negedge
  task automatic tick();
    logic hz;
    #1;
    hz = hazard();
    check_outputs(hz);
    last_acc = id_bus.id_valid && !stall && !hz;
    @(posedge clk);
    model_edge(hz);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    id_bus.id_valid = 0; id_bus.id_rs_data = 0; id_bus.id_rt_data = 0; id_bus.id_imm = 0;
    id_bus.id_rs = 0; id_bus.id_rt = 0; id_bus.id_rd = 0; id_bus.id_alu_src = 0;
    id_bus.id_ALUCtrl = 0; id_bus.id_reg_write = 0; id_bus.id_mem_read = 0;
    stall = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic set_instr(input logic [DW-1:0] rsd, input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                           input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                           input logic src, input logic [CW-1:0] ctrl, input logic rw, input logic mr);
    id_bus.id_valid = 1; id_bus.id_rs_data = rsd; id_bus.id_rt_data = rtd; id_bus.id_imm = imm;
    id_bus.id_rs = rs; id_bus.id_rt = rt; id_bus.id_rd = rd; id_bus.id_alu_src = src;
    id_bus.id_ALUCtrl = ctrl; id_bus.id_reg_write = rw; id_bus.id_mem_read = mr;
  endtask

  initial begin
    drive_idle();
    model_clear();
    last_acc = 1;
    rst = 1;

    // Reset held two cycles with a valid instruction on the bus
    set_instr(32'd11, 32'd22, 32'd33, 5'd1, 5'd2, 5'd3, 1'b0, ALU_ADD, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    #1;
    check_eq("rst_ex_valid", ex_valid, 0);
    check_eq("rst_input1", input1, 0);
    check_eq("rst_input2", input2, 0);
    check_eq("rst_ctrl", ALUCtrl, 0);
    check_eq("rst_ex_rd", ex_rd, 0);
    check_eq("rst_rw", ex_reg_write, 0);
    check_eq("rst_mr", ex_mem_read, 0);
    rst = 0;
    drive_idle();

    // Basic issue with three different operations
    set_instr(32'd128, 32'd128, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, ALU_ADD, 1'b1, 1'b0);
    tick();
    #1;
    check_eq("basic_in1", input1, 32'd128);
    check_eq("basic_in2", input2, 32'd128);
    check_eq("basic_add", ALUCtrl, 4'b0010);
    id_bus.id_ALUCtrl = ALU_SUB;
    tick();
    #1;
    check_eq("basic_sub", ALUCtrl, 4'b0110);
    id_bus.id_ALUCtrl = ALU_SLT;
    tick();
    #1;
    check_eq("basic_slt", ALUCtrl, 4'b0111);
    check_eq("basic_valid", ex_valid, 1);

    // Forward priority on rs=3
    set_instr(32'd77, 32'd1, 32'd0, 5'd3, 5'd6, 5'd7, 1'b0, ALU_ADD, 1'b1, 1'b0);
    tick();
    id_bus.id_valid = 0;
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'd5;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'd9;
    #1;
    check_eq("fwd_exmem", input1, 32'd5);
    exmem_reg_write = 0;
    #1;
    check_eq("fwd_memwb", input1, 32'd9);
    exmem_reg_write = 0; memwb_reg_write = 0;

    // Index 0 must never be forwarded
    set_instr(32'd42, 32'd1, 32'd0, 5'd0, 5'd6, 5'd7, 1'b0, ALU_OR, 1'b1, 1'b0);
    tick();
    id_bus.id_valid = 0;
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'd5;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'd9;
    #1;
    check_eq("fwd_r0", input1, 32'd42);

    // Immediate beats an active rt forward
    drive_idle();
    set_instr(32'd1, 32'd2, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd8, 1'b1, ALU_ADD, 1'b1, 1'b0);
    tick();
    id_bus.id_valid = 0;
    memwb_reg_write = 1; memwb_rd = 5'd2; memwb_result = 32'h1234_5678;
    #1;
    check_eq("imm_in2", input2, 32'hFFFF_FFF0);
    drive_idle();

    // Load-use: load rd=4 followed by a reader of r4
    set_instr(32'd100, 32'd0, 32'd8, 5'd9, 5'd0, 5'd4, 1'b1, ALU_ADD, 1'b1, 1'b1);
    tick();
    set_instr(32'd50, 32'd60, 32'd0, 5'd4, 5'd5, 5'd10, 1'b0, ALU_OR, 1'b1, 1'b0);
    #1;
    check_eq("lu_ready_low", id_bus.id_ready, 0);
    tick();
    #1;
    check_eq("lu_bubble_valid", ex_valid, 0);
    check_eq("lu_bubble_ctrl", ALUCtrl, 4'b0000);
    check_eq("lu_ready_back", id_bus.id_ready, 1);
    tick();
    #1;
    check_eq("lu_issue_valid", ex_valid, 1);
    check_eq("lu_issue_ctrl", ALUCtrl, ALU_OR);
    check_eq("lu_issue_in1", input1, 32'd50);

    // Stall for three cycles, then flush while stalled
    set_instr(32'd7, 32'd8, 32'd0, 5'd11, 5'd12, 5'd13, 1'b0, ALU_AND, 1'b1, 1'b0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check_eq("stall_ready", id_bus.id_ready, 0);
      check_eq("stall_in1", input1, 32'd50);
      check_eq("stall_ctrl", ALUCtrl, ALU_OR);
    end
    flush = 1;
    tick();
    #1;
    check_eq("flush_valid", ex_valid, 0);
    drive_idle();

    // Randomized traffic from a decode source that holds until accepted
    last_acc = 1;
    for (int c = 0; c < 400; c++) begin
      if (!id_bus.id_valid || last_acc) begin
        id_bus.id_valid     = ($urandom_range(3) != 0);
        id_bus.id_rs_data   = $urandom;
        id_bus.id_rt_data   = $urandom;
        id_bus.id_imm       = $urandom;
        id_bus.id_rs        = AW'($urandom_range(7));
        id_bus.id_rt        = AW'($urandom_range(7));
        id_bus.id_rd        = AW'($urandom_range(7));
        id_bus.id_alu_src   = 1'($urandom_range(1));
        id_bus.id_ALUCtrl   = CW'($urandom_range(15));
        id_bus.id_reg_write = 1'($urandom_range(1));
        id_bus.id_mem_read  = ($urandom_range(2) == 0);
      end
      stall           = ($urandom_range(7) == 0);
      flush           = ($urandom_range(15) == 0);
      exmem_reg_write = 1'($urandom_range(1));
      exmem_rd        = AW'($urandom_range(7));
      exmem_result    = $urandom;
      memwb_reg_write = 1'($urandom_range(1));
      memwb_rd        = AW'($urandom_range(7));
      memwb_result    = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
